// File: rtl/sound_pkg.sv
// Shared constants for the sound frame sequencer: which frame steps fire which
// strobe, plus channel indices for the per-channel trigger/start/enable buses.
package sound_pkg;

  // Bit n set means the strobe fires when the tick executes step n
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  localparam int CH_SQ1   = 0;
  localparam int CH_SQ2   = 1;
  localparam int CH_WAVE  = 2;
  localparam int CH_NOISE = 3;
  localparam int NUM_CH   = 4;

  typedef struct packed {
    logic len;
    logic sweep;
    logic env;
  } strobe_t;

  function automatic strobe_t step_strobes(input logic [2:0] s);
    strobe_t r;
    r.len   = LEN_STEPS[s];
    r.sweep = SWEEP_STEPS[s];
    r.env   = ENV_STEPS[s];
    return r;
  endfunction

endpackage

// File: rtl/sound_start_stretch.sv
// Stretches a one-cycle trigger request into a registered START_LEN-cycle start
// pulse; a repeat request reloads the counter so the pulse extends without a gap.
module sound_start_stretch #(
  parameter int START_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  output logic start
);

  localparam int SC_W = $clog2(START_LEN + 1);

  logic [SC_W-1:0] sc;
  logic [SC_W-1:0] sc_nxt;

  always_comb begin
    sc_nxt = sc;
    if (clr) begin
      sc_nxt = '0;
    end else if (req) begin
      sc_nxt = SC_W'(START_LEN);
    end else if (sc != '0) begin
      sc_nxt = sc - SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc    <= '0;
      start <= 1'b0;
    end else begin
      sc    <= sc_nxt;
      start <= (sc_nxt != '0);
    end
  end

endmodule

// File: rtl/sound_seq.sv
// Frame sequencer (512 Hz step clock with length/sweep/envelope strobes), per-channel
// trigger stretchers and NR52 status assembly, all gated by the master sound enable.
module sound_seq
  import sound_pkg::*;
#(
  parameter int PRESCALE  = 8192,
  parameter int START_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_on,
  input  logic [3:0] trig_req,
  input  logic [3:0] ch_enable,
  output logic [3:0] start,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [2:0] step,
  output logic [3:0] nr52_status
);

  localparam int                PRE_W   = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  strobe_t          strb;

  assign tick = sound_on && (pre_cnt == PRE_MAX);
  assign strb = step_strobes(step);

  // Prescaler and step counter restart from zero whenever sound is off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      step    <= 3'd0;
    end else if (!sound_on) begin
      pre_cnt <= '0;
      step    <= 3'd0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PRE_W'(1);
      if (tick) begin
        step <= step + 3'd1;
      end
    end
  end

  // Strobes decode the step being executed, before it advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      clk_length_ctr <= tick && strb.len;
      clk_sweep      <= tick && strb.sweep;
      clk_vol_env    <= tick && strb.env;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sound_start_stretch #(
      .START_LEN(START_LEN)
    ) u_stretch (
      .clk  (clk),
      .rst  (rst),
      .clr  (~sound_on),
      .req  (trig_req[i]),
      .start(start[i])
    );
  end

  assign nr52_status = ch_enable & {4{sound_on}};

endmodule

// File: tb/tb_sound_seq.sv
// Bench for sound_seq: directed sequences from the frame/trigger rules plus random
// traffic, every cycle compared against an arithmetic model of the sequencer.
module tb_sound_seq;

  localparam int P  = 8;
  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sound_on;
  logic [3:0] trig_req;
  logic [3:0] ch_enable;
  logic [3:0] start;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] step;
  logic [3:0] nr52_status;

  int n_tests = 0;
  int n_fail  = 0;

  sound_seq #(
    .PRESCALE (P),
    .START_LEN(SL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sound_on      (sound_on),
    .trig_req      (trig_req),
    .ch_enable     (ch_enable),
    .start         (start),
    .clk_length_ctr(clk_length_ctr),
    .clk_sweep     (clk_sweep),
    .clk_vol_env   (clk_vol_env),
    .step          (step),
    .nr52_status   (nr52_status)
  );

  always #5 clk = ~clk;

  // Model: edge_n counts edges since reset release (after an edge it equals the
  // cycle label of the outputs now visible); on_cnt counts edges since sound_on rose.
  int         edge_n;
  int         on_cnt;
  int         last_req[4];
  logic       m_len, m_sw, m_env;
  logic [3:0] m_start;
  int         m_step;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    on_cnt = 0;
    for (int i = 0; i < 4; i++) last_req[i] = -1000;
    m_len = 0; m_sw = 0; m_env = 0; m_start = 0; m_step = 0;
  endtask

  task automatic model_edge();
    int  s;
    logic tk;
    if (!sound_on) begin
      on_cnt = 0;
      m_len = 0; m_sw = 0; m_env = 0;
      for (int i = 0; i < 4; i++) last_req[i] = -1000;
    end else begin
      s     = (on_cnt / P) % 8;
      tk    = (on_cnt % P) == (P - 1);
      m_len = tk && (s % 2 == 0);
      m_sw  = tk && (s == 2 || s == 6);
      m_env = tk && (s == 7);
      for (int i = 0; i < 4; i++) if (trig_req[i]) last_req[i] = edge_n;
      on_cnt++;
    end
    for (int i = 0; i < 4; i++) m_start[i] = (edge_n - last_req[i]) < SL;
    m_step = (on_cnt / P) % 8;
    edge_n++;
  endtask

  task automatic cycle();
    logic [13:0] a, e;
    @(posedge clk);
    model_edge();
    #1;
    a = {start, clk_length_ctr, clk_sweep, clk_vol_env, step, nr52_status};
    e = {m_start, m_len, m_sw, m_env, m_step[2:0], ch_enable & {4{sound_on}}};
    check("outputs", 32'(a), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b0; sound_on = 1'b0; trig_req = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({start, clk_length_ctr, clk_sweep, clk_vol_env, step, nr52_status}), 32'd0);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Asserts reset mid-cycle, expects every output low at once, then releases it
  task automatic async_rst_check(input string name);
    #2;
    rst = 1'b0; sound_on = 1'b0; trig_req = 4'b0;
    #1;
    check(name, 32'({start, clk_length_ctr, clk_sweep, clk_vol_env, step, nr52_status}), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       so;
    logic [3:0] en;
    logic [3:0] exp;
  } nr52_vec_t;

  nr52_vec_t nv[6];
  int        q_len[$], q_sw[$], q_env[$];
  int        exp_len[8] = '{8, 24, 40, 56, 72, 88, 104, 120};
  int        exp_sw[4]  = '{24, 56, 88, 120};
  int        exp_env[2] = '{64, 128};

  initial begin
    int   hi, rises, first, cnt;
    logic prev;
    logic [3:0] acc;

    nv[0] = '{1'b1, 4'b1011, 4'b1011};
    nv[1] = '{1'b0, 4'b1011, 4'b0000};
    nv[2] = '{1'b1, 4'b0000, 4'b0000};
    nv[3] = '{1'b1, 4'b1111, 4'b1111};
    nv[4] = '{1'b0, 4'b1111, 4'b0000};
    nv[5] = '{1'b1, 4'b0110, 4'b0110};

    ch_enable = 4'b0000;
    model_reset();
    do_reset();

    // Free-running frame sequence for 128 cycles
    sound_on = 1'b1;
    for (int k = 0; k < 128; k++) begin
      cycle();
      if (clk_length_ctr) q_len.push_back(edge_n);
      if (clk_sweep)      q_sw.push_back(edge_n);
      if (clk_vol_env)    q_env.push_back(edge_n);
      if (edge_n == 64) check("step_wrap_at_64", 32'(step), 32'd0);
    end
    check("len_count", q_len.size(), 8);
    check("sweep_count", q_sw.size(), 4);
    check("env_count", q_env.size(), 2);
    for (int i = 0; i < 8; i++) if (i < q_len.size()) check("len_cycle", q_len[i], exp_len[i]);
    for (int i = 0; i < 4; i++) if (i < q_sw.size())  check("sweep_cycle", q_sw[i], exp_sw[i]);
    for (int i = 0; i < 2; i++) if (i < q_env.size()) check("env_cycle", q_env[i], exp_env[i]);

    // Noise trigger: exactly START_LEN cycles of start=1000
    trig_req = 4'b1000;
    cycle();
    check("noise_first", 32'(start), 32'h8);
    trig_req = 4'b0000;
    hi = 1; acc = start & 4'b0111;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (start[3]) hi++;
      acc |= start & 4'b0111;
    end
    check("noise_len", hi, SL);
    check("noise_others", 32'(acc), 32'd0);

    // Retrigger of square1 extends the pulse with a single rising edge
    prev = start[0]; hi = 0; rises = 0;
    for (int k = 0; k < 11; k++) begin
      trig_req = (k == 0 || k == 2) ? 4'b0001 : 4'b0000;
      cycle();
      if (start[0]) hi++;
      if (start[0] && !prev) rises++;
      prev = start[0];
    end
    check("retrig_high", hi, 6);
    check("retrig_rises", rises, 1);

    // sound_on off for cycles 30..39
    do_reset();
    sound_on = 1'b1;
    while (edge_n < 30) cycle();
    sound_on = 1'b0; cnt = 0; acc = 0; first = 0;
    while (edge_n < 40) begin
      trig_req = edge_n[0] ? 4'b1111 : 4'b0101;
      cycle();
      acc |= start;
      if (clk_length_ctr || clk_sweep || clk_vol_env) cnt++;
    end
    trig_req = 4'b0000;
    sound_on = 1'b1;
    while (edge_n < 60) begin
      cycle();
      if (edge_n <= 47 && (clk_length_ctr || clk_sweep || clk_vol_env)) cnt++;
      if (clk_length_ctr && first == 0) first = edge_n;
    end
    check("off_no_strobes", cnt, 0);
    check("off_no_start", 32'(acc), 32'd0);
    check("restart_len", first, 48);

    // Async reset during a strobe cycle and during a start pulse
    do_reset();
    sound_on = 1'b1; first = 0;
    for (int k = 0; k < 40 && first == 0; k++) begin
      cycle();
      if (clk_length_ctr) first = edge_n;
    end
    check("strobe_seen", first, 8);
    async_rst_check("rst_in_strobe");
    sound_on = 1'b1; first = 0;
    for (int k = 0; k < 20 && first == 0; k++) begin
      cycle();
      if (clk_length_ctr) first = edge_n;
    end
    check("len_after_rst", first, 8);
    trig_req = 4'b0101;
    cycle();
    trig_req = 4'b0000;
    cycle();
    check("start_active", 32'(start), 32'h5);
    async_rst_check("rst_in_start");
    sound_on = 1'b1;
    repeat (8) cycle();

    // NR52 status table
    for (int i = 0; i < 6; i++) begin
      sound_on  = nv[i].so;
      ch_enable = nv[i].en;
      #1;
      check("nr52", 32'(nr52_status), 32'(nv[i].exp));
      cycle();
    end

    // Random traffic against the model
    do_reset();
    sound_on = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (sound_on) begin
        if ($urandom_range(0, 149) == 0) sound_on = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        sound_on = 1'b1;
      end
      for (int i = 0; i < 4; i++) trig_req[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) ch_enable = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
